// File: rtl/jt12_i2s_tx_if.sv
// Accumulator-side capture signals and I2S-side outputs of the stereo serializer.
interface jt12_i2s_tx_if;
   logic               clk_en;
   logic               zero;
   logic signed [15:0] left;
   logic signed [15:0] right;
   logic               sample;
   logic               sck;
   logic               ws;
   logic               sd;
   logic [7:0]         ovr_cnt;
   logic [7:0]         udr_cnt;

   modport slave (
      input  clk_en, zero, left, right,
      output sample, sck, ws, sd, ovr_cnt, udr_cnt
   );

   modport master (
      output clk_en, zero, left, right,
      input  sample, sck, ws, sd, ovr_cnt, udr_cnt
   );
endinterface

// File: rtl/jt12_i2s_tx.sv
// Stereo I2S serializer: captures one accumulator sample per round into a one-entry
// holding register and shifts it out as 16-bit MSB-first words with a one-bit WS lead.
module jt12_i2s_tx #(
   parameter int unsigned DIV = 4
) (
   input logic         clk,
   input logic         rst,
   jt12_i2s_tx_if.slave bus
);
   localparam logic [7:0] DivLast = 8'(DIV - 1);

   logic [7:0]  div;
   logic [4:0]  bcnt;
   logic        pend;
   logic        full;
   logic [31:0] hold;
   logic [31:0] last;
   logic [31:0] shifter;
   logic        sck_r;
   logic        ws_r;
   logic        sample_r;
   logic [7:0]  ovr;
   logic [7:0]  udr;

   logic        wrap;
   logic        fall;
   logic        load;
   logic        capture;
   logic [4:0]  bcnt_nxt;

   always_comb begin
      wrap     = (div == DivLast);
      fall     = wrap & sck_r;
      bcnt_nxt = bcnt + 5'd1;
      load     = fall & (bcnt_nxt == 5'd1);
      capture  = bus.clk_en & pend;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= 8'd0;
         bcnt     <= 5'd0;
         pend     <= 1'b0;
         full     <= 1'b0;
         hold     <= 32'd0;
         last     <= 32'd0;
         shifter  <= 32'd0;
         sck_r    <= 1'b0;
         ws_r     <= 1'b0;
         sample_r <= 1'b0;
         ovr      <= 8'd0;
         udr      <= 8'd0;
      end else begin
         if (wrap) begin
            div   <= 8'd0;
            sck_r <= ~sck_r;
         end else begin
            div <= div + 8'd1;
         end

         if (fall) begin
            bcnt <= bcnt_nxt;
            ws_r <= bcnt_nxt[4];
            if (load) begin
               // An empty buffer repeats the previous frame and counts as an underrun
               if (full) begin
                  shifter <= hold;
                  last    <= hold;
               end else begin
                  shifter <= last;
                  if (udr != 8'hFF) udr <= udr + 8'd1;
               end
            end else begin
               shifter <= {shifter[30:0], 1'b0};
            end
         end

         sample_r <= capture;
         if (bus.clk_en) pend <= bus.zero;

         // Load sees the pre-capture hold/full; a same-clk capture refills the buffer
         if (capture) begin
            hold <= {bus.left, bus.right};
            full <= 1'b1;
            if (full && !load && ovr != 8'hFF) ovr <= ovr + 8'd1;
         end else if (load) begin
            full <= 1'b0;
         end
      end
   end

   assign bus.sample  = sample_r;
   assign bus.sck     = sck_r;
   assign bus.ws      = ws_r;
   assign bus.sd      = shifter[31];
   assign bus.ovr_cnt = ovr;
   assign bus.udr_cnt = udr;
endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Self-checking bench for jt12_i2s_tx: time-based reference model checked every clk,
// table-driven frame vectors and hand sequences for capture/load/reset corner cases.
module tb_jt12_i2s_tx;
   localparam int unsigned DIV       = 4;
   localparam int unsigned SckPer    = 2 * DIV;
   localparam int unsigned FrameClks = 64 * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jt12_i2s_tx_if bus ();

   jt12_i2s_tx #(.DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired, required event never seen", name);
   endtask

   // Reference model: time since reset drives sck/bcnt arithmetically; a frame word
   // is chosen at each bcnt->1 event and sd is that word's bit for the current slot.
   int          m_t;
   int          m_bcnt;
   bit          m_fall;
   logic [31:0] m_hold, m_last, m_frame;
   bit          m_full, m_pend, m_sample;
   int          m_ovr, m_udr;
   bit          m_ld, m_cap, m_was_full;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_t = 0; m_bcnt = 0; m_fall = 0;
         m_hold = 0; m_last = 0; m_frame = 0;
         m_full = 0; m_pend = 0; m_sample = 0; m_ovr = 0; m_udr = 0;
      end else begin
         m_t++;
         m_fall     = (m_t % SckPer) == 0;
         m_bcnt     = (m_t / SckPer) % 32;
         m_ld       = m_fall && (m_bcnt == 1);
         m_cap      = bus.clk_en && m_pend;
         m_was_full = m_full;
         if (m_ld) begin
            if (m_was_full) begin
               m_frame = m_hold;
               m_last  = m_hold;
               m_full  = 0;
            end else begin
               m_frame = m_last;
               if (m_udr < 255) m_udr++;
            end
         end
         if (m_cap) begin
            if (m_was_full && !m_ld && m_ovr < 255) m_ovr++;
            m_hold = {bus.left, bus.right};
            m_full = 1;
         end
         m_sample = m_cap;
         if (bus.clk_en) m_pend = bus.zero;
      end
   end

   int   c_idx;
   logic c_sd, c_sck, c_ws;
   always @(negedge clk) begin
      if (chk_en) begin
         c_idx = 31 - ((m_bcnt + 31) % 32);
         c_sd  = m_frame[c_idx];
         c_sck = 1'((m_t / DIV) % 2);
         c_ws  = (m_bcnt >= 16);
         check("model_outputs",
               64'({bus.sample, bus.sck, bus.ws, bus.sd, bus.ovr_cnt, bus.udr_cnt}),
               64'({m_sample, c_sck, c_ws, c_sd, 8'(m_ovr), 8'(m_udr)}));
      end
   end

   task automatic wait_bcnt(input int b);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_fall && m_bcnt == b) && n < 2 * FrameClks);
      if (!(m_fall && m_bcnt == b)) timeout("wait_bcnt");
   endtask

   task automatic wait_fall();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_fall && n < 4 * SckPer);
      if (!m_fall) timeout("wait_fall");
   endtask

   task automatic wait_phase(input int ph);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((m_t % FrameClks) != ph && n < 2 * FrameClks);
      if ((m_t % FrameClks) != ph) timeout("wait_phase");
   endtask

   // Caller sits on the negedge right after a frame load
   task automatic collect_here(output logic [31:0] w);
      w[31] = bus.sd;
      for (int i = 30; i >= 0; i--) begin
         wait_fall();
         w[i] = bus.sd;
      end
   endtask

   task automatic collect_frame(output logic [31:0] w);
      wait_bcnt(1);
      collect_here(w);
   endtask

   task automatic capture(input logic [15:0] l, input logic [15:0] r);
      bus.zero  = 1'b1;
      bus.left  = l;
      bus.right = r;
      @(negedge clk);
      bus.zero = 1'b0;
      check("sample_before", 64'(bus.sample), 64'(0));
      @(negedge clk);
      check("sample_pulse", 64'(bus.sample), 64'(1));
      @(negedge clk);
      check("sample_after", 64'(bus.sample), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[4];
   logic [31:0] w;
   logic        prev_sck;
   int          n;

   initial begin
      tbl[0] = '{16'h8001, 16'h7FFE, 32'h80017FFE};
      tbl[1] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
      tbl[2] = '{16'h1234, 16'hABCD, 32'h1234ABCD};
      tbl[3] = '{16'h0000, 16'h8000, 32'h00008000};

      bus.clk_en = 1'b0;
      bus.zero   = 1'b0;
      bus.left   = 16'd0;
      bus.right  = 16'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs",
            64'({bus.sample, bus.sck, bus.ws, bus.sd, bus.ovr_cnt, bus.udr_cnt}), 64'(0));
      rst = 1'b0;

      // Idle: first load at 2*DIV clks is an underrun; counter saturates
      repeat (SckPer) @(negedge clk);
      check("udr_first", 64'(bus.udr_cnt), 64'(1));
      repeat (260 * FrameClks) @(negedge clk);
      check("udr_saturate", 64'(bus.udr_cnt), 64'(255));
      check("idle_sd", 64'(bus.sd), 64'(0));

      do_reset();
      bus.clk_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_bcnt(8);
         capture(tbl[i].l, tbl[i].r);
         collect_frame(w);
         check($sformatf("frame_word[%0d]", i), 64'(w), 64'(tbl[i].exp));
      end

      // Two captures in one frame: the later one is sent, one overrun
      wait_bcnt(3);
      capture(16'd1, 16'h5555);
      wait_bcnt(10);
      capture(16'd2, 16'h5555);
      check("ovr_count", 64'(bus.ovr_cnt), 64'(1));
      collect_frame(w);
      check("ovr_left", 64'(w[31:16]), 64'(2));
      check("ovr_right", 64'(w[15:0]), 64'(16'h5555));

      // Capture landing on the load clk with full=1
      wait_bcnt(8);
      capture(16'h0A0A, 16'h0B0B);
      wait_phase(SckPer - 2);
      bus.zero  = 1'b1;
      bus.left  = 16'h0C0C;
      bus.right = 16'h0D0D;
      @(negedge clk);
      bus.zero = 1'b0;
      @(negedge clk);
      check("collision_sample", 64'(bus.sample), 64'(1));
      check("collision_ovr", 64'(bus.ovr_cnt), 64'(1));
      collect_here(w);
      check("collision_old", 64'(w), 64'(32'h0A0A0B0B));
      collect_frame(w);
      check("collision_new", 64'(w), 64'(32'h0C0C0D0D));

      // clk_en 1-of-3: capture waits for the next enabled clk
      wait_bcnt(5);
      bus.zero  = 1'b1;
      bus.left  = 16'h3C3C;
      bus.right = 16'hC3C3;
      @(negedge clk);
      bus.zero   = 1'b0;
      bus.clk_en = 1'b0;
      check("en_wait0", 64'(bus.sample), 64'(0));
      @(negedge clk);
      check("en_wait1", 64'(bus.sample), 64'(0));
      @(negedge clk);
      bus.clk_en = 1'b1;
      check("en_wait2", 64'(bus.sample), 64'(0));
      @(negedge clk);
      check("en_capture", 64'(bus.sample), 64'(1));
      collect_frame(w);
      check("en_frame", 64'(w), 64'(32'h3C3CC3C3));

      // Randomized traffic checked against the model every clk
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         bus.clk_en = ($urandom % 3) != 0;
         bus.zero   = ($urandom % 40) == 0;
         bus.left   = 16'($urandom);
         bus.right  = 16'($urandom);
      end
      bus.clk_en = 1'b1;
      bus.zero   = 1'b0;

      // Reset mid-frame
      wait_bcnt(20);
      rst = 1'b1;
      @(negedge clk);
      check("midframe_reset",
            64'({bus.sample, bus.sck, bus.ws, bus.sd, bus.ovr_cnt, bus.udr_cnt}), 64'(0));
      rst      = 1'b0;
      prev_sck = bus.sck;
      n        = 0;
      do begin
         @(negedge clk);
         n++;
         if (prev_sck && !bus.sck) break;
         prev_sck = bus.sck;
      end while (n < 100);
      check("first_fall_clks", 64'(n), 64'(8));
      repeat (FrameClks) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
